// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler and its companion up-counter.
package pulse_sched_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int REP_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pulse_sched_counter.sv
// Free-running up-counter driven by the scheduler: counts while enabled,
// clears on any disabled cycle, and flags a match against the trigger.
module pulse_sched_counter
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_trigger,
  output logic             o_pulse
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_count <= '0;
    else if (i_en) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    else           r_count <= '0;
  end

  assign o_pulse = (r_count == i_trigger);

endmodule

// File: rtl/pulse_scheduler.sv
// Issues repeat_n ticks, each one period+2 cycles apart, by gating an
// external up-counter; every output is a flop so downstream sees clean pulses.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [REP_W-1:0] repeat_n,
  input  logic             cnt_pulse,
  output logic             cnt_en,
  output logic [CNT_W-1:0] cnt_trigger,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [REP_W-1:0] ticks_done
);

  state_t           r_state, w_state_nxt;
  logic [REP_W-1:0] r_rep, w_rep_nxt;
  logic [CNT_W-1:0] r_trig, w_trig_nxt;
  logic [REP_W-1:0] r_ticks, w_ticks_nxt;
  logic             r_en, r_busy, r_tick, r_done;
  logic             w_tick_nxt, w_done_nxt;
  logic [REP_W:0]   w_ticks_inc;

  assign w_ticks_inc = {1'b0, r_ticks} + {{REP_W{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_rep_nxt   = r_rep;
    w_trig_nxt  = r_trig;
    w_ticks_nxt = r_ticks;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_trig_nxt  = period;
          w_rep_nxt   = repeat_n;
          w_ticks_nxt = '0;
          // A zero-length schedule completes immediately without touching the counter
          if (period == '0 || repeat_n == '0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_ARM;
          end
        end
      end
      ST_ARM:  w_state_nxt = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (cnt_pulse) begin
          if (r_ticks != r_rep) w_ticks_nxt = w_ticks_inc[REP_W-1:0];
          w_tick_nxt = 1'b1;
          if (w_ticks_inc < {1'b0, r_rep}) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_GAP:  w_state_nxt = abort ? ST_IDLE : ST_RUN;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rep   <= '0;
      r_trig  <= '0;
      r_ticks <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rep   <= w_rep_nxt;
      r_trig  <= w_trig_nxt;
      r_ticks <= w_ticks_nxt;
      r_en    <= (w_state_nxt == ST_RUN);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign cnt_en      = r_en;
  assign cnt_trigger = r_trig;
  assign busy        = r_busy;
  assign tick        = r_tick;
  assign done        = r_done;
  assign ticks_done  = r_ticks;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scheduler paired with the real up-counter; an arithmetic timeline model
// predicts every output each cycle, and directed scenarios pin literal timings.
module tb_pulse_scheduler;
  import pulse_sched_pkg::*;

  localparam int CW = CNT_W_DEF;
  localparam int RW = REP_W_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [CW-1:0] period = '0;
  logic [RW-1:0] repeat_n = '0;
  logic          cnt_pulse, cnt_en, busy, tick, done;
  logic [CW-1:0] cnt_trigger;
  logic [RW-1:0] ticks_done;

  always #5 clk = ~clk;

  pulse_scheduler #(.CNT_W(CW), .REP_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .period(period),
    .repeat_n(repeat_n), .cnt_pulse(cnt_pulse), .cnt_en(cnt_en),
    .cnt_trigger(cnt_trigger), .busy(busy), .tick(tick), .done(done),
    .ticks_done(ticks_done)
  );

  pulse_sched_counter #(.CNT_W(CW)) u_cnt (
    .i_clk(clk), .i_rst(rst), .i_en(cnt_en), .i_trigger(cnt_trigger),
    .o_pulse(cnt_pulse)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  bit chk_en = 0;
  int tick_q[$], done_q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qget(ref int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Model: a schedule is a timeline starting at m_s (first busy cycle).
  // Elapsed t: tick when t is a nonzero multiple of period+2, done at R*(period+2).
  bit m_act = 0, m_zero = 0;
  int m_s = 0, m_len = 0, m_per = 0, m_R = 0, m_hold = 0, m_trig = 0;

  always @(posedge clk or posedge rst) begin : model
    int tp;
    if (rst) begin
      m_act = 0; m_hold = 0; m_trig = 0;
    end else begin
      tp = cyc - m_s;
      if (m_act) begin
        if (tp >= m_len) begin
          m_act = 0; m_hold = m_zero ? 0 : m_R;
        end else if (abort) begin
          m_act = 0; m_hold = tp / m_per;
        end
      end else if (start && !abort) begin
        m_act  = 1; m_s = cyc + 1; m_per = int'(period) + 2; m_R = int'(repeat_n);
        m_trig = int'(period);
        m_zero = (period == 0) || (repeat_n == 0);
        m_len  = m_zero ? 0 : m_R * m_per;
        m_hold = 0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin : cmp
    int t;
    logic [31:0] eb, et, ed, ee, etd;
    if (tick === 1'b1) tick_q.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
    if (chk_en) begin
      eb = 0; et = 0; ed = 0; ee = 0; etd = m_hold;
      if (m_act) begin
        t = cyc - m_s; eb = 1;
        if (m_zero) begin
          ed = 1; etd = 0;
        end else begin
          et  = (t > 0 && t % m_per == 0) ? 1 : 0;
          ed  = (t == m_len) ? 1 : 0;
          ee  = (t % m_per != 0) ? 1 : 0;
          etd = t / m_per;
        end
      end
      chk("busy", busy, eb);
      chk("tick", tick, et);
      chk("done", done, ed);
      chk("cnt_en", cnt_en, ee);
      chk("ticks_done", ticks_done, etd);
      chk("cnt_trigger", cnt_trigger, m_trig);
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int p, input int r, output int c);
    c = cyc; start = 1'b1; period = CW'(p); repeat_n = RW'(r);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) return;
      step();
    end
    n_vec++; n_err++;
    $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, budget);
  endtask

  task automatic clrq();
    tick_q.delete(); done_q.delete();
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c, bad;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_trig", cnt_trigger, 0);
    chk("rst_ticks", ticks_done, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; chk_en = 1;
    step(2);

    // period=3, repeat=2
    clrq(); launch(3, 2, c); wait_idle(50);
    chk("t1_idle_at", cyc, c + 12);
    chk("t1_ntick", tick_q.size(), 2);
    chk("t1_tick0", qget(tick_q, 0), c + 6);
    chk("t1_tick1", qget(tick_q, 1), c + 11);
    chk("t1_done", qget(done_q, 0), c + 11);
    chk("t1_ticks_done", ticks_done, 2);
    step(2);

    // zero period completes at once
    clrq(); launch(0, 5, c); wait_idle(20);
    chk("t2_done", qget(done_q, 0), c + 1);
    chk("t2_ntick", tick_q.size(), 0);
    chk("t2_ticks_done", ticks_done, 0);
    chk("t2_idle_at", cyc, c + 2);
    step(2);

    // abort during the second RUN
    clrq(); launch(4, 3, c);
    step(8);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_en", cnt_en, 0);
    chk("t3_ticks_done", ticks_done, 1);
    chk("t3_ndone", done_q.size(), 0);
    step(3);
    chk("t3_ntick", tick_q.size(), 1);

    // start re-pulsed mid-schedule is ignored
    clrq(); launch(3, 2, c);
    step(3);
    start = 1'b1; period = CW'(9); step(); start = 1'b0;
    chk("t4_trig", cnt_trigger, 3);
    wait_idle(50);
    chk("t4_tick0", qget(tick_q, 0), c + 6);
    chk("t4_tick1", qget(tick_q, 1), c + 11);
    chk("t4_done", qget(done_q, 0), c + 11);
    step(2);

    // asynchronous reset mid-RUN
    clrq(); launch(5, 2, c);
    step(3);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_en", cnt_en, 0);
    chk("t5_trig", cnt_trigger, 0);
    chk("t5_ticks", ticks_done, 0);
    chk("t5_tick", tick, 0);
    chk("t5_done", done, 0);
    step(2); rst = 1'b0; step();
    chk("t5_ndone", done_q.size(), 0);
    clrq(); launch(2, 2, c); wait_idle(40);
    chk("t5_tick0", qget(tick_q, 0), c + 5);
    chk("t5_tick1", qget(tick_q, 1), c + 9);
    chk("t5_done2", qget(done_q, 0), c + 9);
    chk("t5_ticks_done", ticks_done, 2);
    step(2);

    // long schedule, no wrap
    clrq(); launch(1, 255, c); wait_idle(1000);
    chk("t6_ntick", tick_q.size(), 255);
    chk("t6_tick0", qget(tick_q, 0), c + 4);
    bad = 0;
    for (int i = 1; i < tick_q.size(); i++)
      if (tick_q[i] - tick_q[i-1] != 3) bad++;
    chk("t6_spacing", bad, 0);
    chk("t6_ticks_done", ticks_done, 255);
    chk("t6_done", qget(done_q, 0), c + 766);
    step(3);
    chk("t6_hold", ticks_done, 255);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; period = CW'(2); repeat_n = RW'(1);
    step(); start = 1'b0; abort = 1'b0;
    chk("t7_busy", busy, 0);
    step();
    chk("t7_busy2", busy, 0);

    // randomized schedules with stray start/abort pulses
    for (int it = 0; it < 60; it++) begin
      launch($urandom_range(0, 6), $urandom_range(0, 4), c);
      for (int i = 0; i < 300 && busy === 1'b1; i++) begin
        abort  = ($urandom_range(0, 29) == 0);
        start  = ($urandom_range(0, 7) == 0);
        period = CW'($urandom_range(0, 9));
        step();
      end
      start = 1'b0; abort = 1'b0;
      step($urandom_range(0, 2));
    end
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
